rc4_stream_core: RTL and testbench

//  Parametrised RC4 keystream engine; successor to the fixed-length rc4_new_design.
//  - Runtime key length up to MAX_KEY_BYTES; optional RC4-drop[n] discard.
//  - Unbounded or counted keystream over a valid/ready byte stream, with abort.
//  - Feeds the XOR datapath of the cipher top; one keystream byte per cycle when ks_ready is high.

---
 rtl/rc4_pkg.sv | 15 +
 rtl/rc4_sbox.sv | 37 +++
 rtl/rc4_stream_core.sv | 200 ++++++++++++++++++++
 tb/tb_rc4_stream_core.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared state encoding and constants for the RC4 keystream core
package rc4_pkg;

    localparam int SBOX_SIZE = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_DROP,
        ST_PRGA,
        ST_DONE
    } rc4_state_e;

endpackage

// File: rtl/rc4_sbox.sv
// rtl/rc4_sbox.sv - 256x8 RC4 permutation register file with bulk init and single-cycle swap
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       init_all,
    input  logic       swap_en,
    input  logic [7:0] swap_a,
    input  logic [7:0] swap_b,
    input  logic [7:0] rd_addr_a,
    input  logic [7:0] rd_addr_b,
    input  logic [7:0] rd_addr_c,
    output logic [7:0] rd_data_a,
    output logic [7:0] rd_data_b,
    output logic [7:0] rd_data_c
);

    // Contents are deliberately unreset: init_all rewrites the whole table before any use.
    logic [7:0] mem_q [SBOX_SIZE];

    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];
    assign rd_data_c = mem_q[rd_addr_c];

    // Identity fill on init_all, otherwise exchange two entries (same-address swap leaves S untouched).
    always_ff @(posedge clk) begin
        if (init_all) begin
            for (int n = 0; n < SBOX_SIZE; n++) begin
                mem_q[n] <= 8'(n);
            end
        end else if (swap_en && (swap_a != swap_b)) begin
            mem_q[swap_a] <= mem_q[swap_b];
            mem_q[swap_b] <= mem_q[swap_a];
        end
    end

endmodule

// File: rtl/rc4_stream_core.sv
// rtl/rc4_stream_core.sv - parametrised RC4 keystream engine with drop, counted output and abort
module rc4_stream_core
    import rc4_pkg::*;
#(
    parameter int MAX_KEY_BYTES = 16,
    parameter int CNT_W         = 32,
    parameter int DROP_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [MAX_KEY_BYTES*8-1:0] key,
    input  logic [7:0]                 key_length,
    input  logic [DROP_W-1:0]          drop_count,
    input  logic [CNT_W-1:0]           byte_count,
    output logic [7:0]                 ks_data,
    output logic                       ks_valid,
    input  logic                       ks_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       key_err
);

    rc4_state_e state_q, state_d;

    logic [7:0]                 i_q, i_d;
    logic [7:0]                 j_q, j_d;
    logic [7:0]                 kidx_q, kidx_d;
    logic [7:0]                 klen_q, klen_d;
    logic [MAX_KEY_BYTES*8-1:0] key_q, key_d;
    logic [DROP_W-1:0]          drop_q, drop_d;
    logic [CNT_W-1:0]           bcnt_q, bcnt_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [7:0]                 ks_data_q, ks_data_d;
    logic                       ks_valid_q, ks_valid_d;
    logic                       key_err_q, key_err_d;

    logic       key_ok, start_ok;
    logic [7:0] key_byte;
    logic [7:0] i_nx, j_sel, ksa_j, prga_j, t_idx, z_byte;
    logic [7:0] addr_a, s_a, s_b, s_c;
    logic       hs, last_hs, prga_step, swap_en, init_all;

    assign key_ok   = (key_length != 8'd0) && ({24'd0, key_length} <= 32'(MAX_KEY_BYTES));
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Select key byte i mod key_length, tracked by a wrapping index instead of a divider.
    always_comb begin
        key_byte = 8'd0;
        for (int n = 0; n < MAX_KEY_BYTES; n++) begin
            if (kidx_q == 8'(n)) key_byte = key_q[8*n +: 8];
        end
    end

    // S-box addressing: KSA works on S[i], PRGA/DROP on S[i+1]; z is corrected for the same-cycle swap.
    always_comb begin
        i_nx   = i_q + 8'd1;
        addr_a = (state_q == ST_KSA) ? i_q : i_nx;
        ksa_j  = j_q + s_a + key_byte;
        prga_j = j_q + s_a;
        j_sel  = (state_q == ST_KSA) ? ksa_j : prga_j;
        t_idx  = s_a + s_b;
        if (t_idx == i_nx)       z_byte = s_b;
        else if (t_idx == j_sel) z_byte = s_a;
        else                     z_byte = s_c;
    end

    assign hs        = ks_valid_q && ks_ready;
    assign last_hs   = hs && (bcnt_q != '0) && ((cnt_q + CNT_W'(1)) == bcnt_q);
    assign prga_step = (state_q == ST_PRGA) && (!ks_valid_q || ks_ready) && !last_hs;
    assign swap_en   = (state_q == ST_KSA) || (state_q == ST_DROP) || prga_step;
    assign init_all  = (state_q == ST_INIT);

    rc4_sbox u_sbox (
        .clk       (clk),
        .init_all  (init_all),
        .swap_en   (swap_en),
        .swap_a    (addr_a),
        .swap_b    (j_sel),
        .rd_addr_a (addr_a),
        .rd_addr_b (j_sel),
        .rd_addr_c (t_idx),
        .rd_data_a (s_a),
        .rd_data_b (s_b),
        .rd_data_c (s_c)
    );

    // Next-state logic for the keying/generation sequence; abort overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_ok && key_ok) state_d = ST_INIT;
            ST_INIT:          state_d = ST_KSA;
            ST_KSA:           if (i_q == 8'd255) state_d = (drop_q == '0) ? ST_PRGA : ST_DROP;
            ST_DROP:          if (drop_q == DROP_W'(1)) state_d = ST_PRGA;
            ST_PRGA:          if (last_hs) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath next values: config latch, i/j walk, drop/emit counters and the output register.
    always_comb begin
        i_d        = i_q;
        j_d        = j_q;
        kidx_d     = kidx_q;
        klen_d     = klen_q;
        key_d      = key_q;
        drop_d     = drop_q;
        bcnt_d     = bcnt_q;
        cnt_d      = cnt_q;
        ks_data_d  = ks_data_q;
        ks_valid_d = ks_valid_q;
        key_err_d  = start_ok && !key_ok;

        if (start_ok && key_ok) begin
            key_d  = key;
            klen_d = key_length;
            drop_d = drop_count;
            bcnt_d = byte_count;
            cnt_d  = '0;
        end

        case (state_q)
            ST_INIT: begin
                i_d    = 8'd0;
                j_d    = 8'd0;
                kidx_d = 8'd0;
            end
            ST_KSA: begin
                i_d    = i_nx;
                j_d    = (i_q == 8'd255) ? 8'd0 : ksa_j;
                kidx_d = (kidx_q == (klen_q - 8'd1)) ? 8'd0 : kidx_q + 8'd1;
            end
            ST_DROP: begin
                i_d    = i_nx;
                j_d    = prga_j;
                drop_d = drop_q - DROP_W'(1);
            end
            ST_PRGA: begin
                if (hs) cnt_d = cnt_q + CNT_W'(1);
                if (prga_step) begin
                    i_d        = i_nx;
                    j_d        = prga_j;
                    ks_data_d  = z_byte;
                    ks_valid_d = 1'b1;
                end else if (last_hs) begin
                    ks_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (abort) ks_valid_d = 1'b0;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            kidx_q     <= 8'd0;
            klen_q     <= 8'd0;
            key_q      <= '0;
            drop_q     <= '0;
            bcnt_q     <= '0;
            cnt_q      <= '0;
            ks_data_q  <= 8'd0;
            ks_valid_q <= 1'b0;
            key_err_q  <= 1'b0;
        end else begin
            i_q        <= i_d;
            j_q        <= j_d;
            kidx_q     <= kidx_d;
            klen_q     <= klen_d;
            key_q      <= key_d;
            drop_q     <= drop_d;
            bcnt_q     <= bcnt_d;
            cnt_q      <= cnt_d;
            ks_data_q  <= ks_data_d;
            ks_valid_q <= ks_valid_d;
            key_err_q  <= key_err_d;
        end
    end

    assign ks_data  = ks_data_q;
    assign ks_valid = ks_valid_q;
    assign key_err  = key_err_q;
    assign done     = (state_q == ST_DONE);
    assign busy     = (state_q == ST_INIT) || (state_q == ST_KSA) ||
                      (state_q == ST_DROP) || (state_q == ST_PRGA);

endmodule

// File: tb/tb_rc4_stream_core.sv
// tb/tb_rc4_stream_core.sv - scoreboard bench for rc4_stream_core
module tb_rc4_stream_core;

    localparam logic [127:0] KEY_KEY    = 128'h79654B;
    localparam logic [127:0] KEY_WIKI   = 128'h696B6957;
    localparam logic [127:0] KEY_SECRET = 128'h746572636553;

    logic         clk = 1'b0;
    logic         rst_n, start, abort, ks_ready;
    logic [127:0] key;
    logic [7:0]   key_length;
    logic [15:0]  drop_count;
    logic [31:0]  byte_count;
    logic [7:0]   ks_data;
    logic         ks_valid, busy, done, key_err;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    rc4_stream_core #(.MAX_KEY_BYTES(16), .CNT_W(32), .DROP_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .key        (key),
        .key_length (key_length),
        .drop_count (drop_count),
        .byte_count (byte_count),
        .ks_data    (ks_data),
        .ks_valid   (ks_valid),
        .ks_ready   (ks_ready),
        .busy       (busy),
        .done       (done),
        .key_err    (key_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_bytes(input logic [7:0] b [], input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(b[k]);
    endtask

    task automatic push_model(input logic [127:0] k, input int len, input int drop, input int n);
        logic [7:0] s [256];
        logic [7:0] tmp;
        int ii, jj;
        for (int m = 0; m < 256; m++) s[m] = 8'(m);
        jj = 0;
        for (ii = 0; ii < 256; ii++) begin
            jj = (jj + int'(s[ii]) + int'(k[8*(ii % len) +: 8])) % 256;
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
        end
        ii = 0;
        jj = 0;
        for (int st = 0; st < drop + n; st++) begin
            ii = (ii + 1) % 256;
            jj = (jj + int'(s[ii])) % 256;
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
            if (st >= drop) exp_q.push_back(s[(int'(s[ii]) + int'(s[jj])) % 256]);
        end
    endtask

    task automatic start_run(input logic [127:0] k, input int len, input int drop, input int cnt);
        key        = k;
        key_length = 8'(len);
        drop_count = 16'(drop);
        byte_count = 32'(cnt);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_done(input string name);
        @(negedge clk);
        check({name, "_done"},  32'(done),     32'd1);
        check({name, "_valid"}, 32'(ks_valid), 32'd0);
        check({name, "_busy"},  32'(busy),     32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_abort(input string name);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check({name, "_busy"},  32'(busy),     32'd0);
        check({name, "_valid"}, 32'(ks_valid), 32'd0);
        check({name, "_done"},  32'(done),     32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every handshake and checks data holds steady while stalled.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] exp_b;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n || abort) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(ks_valid), 32'd1);
                    check("stall_data",  32'(ks_data),  32'(prev_data));
                end
                if (ks_valid && ks_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_byte: got %02h, required no byte", ks_data);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("ks_byte", 32'(ks_data), 32'(exp_b));
                    end
                end
                prev_stall = ks_valid && !ks_ready;
                prev_data  = ks_data;
            end
        end
    end

    initial begin
        logic [7:0] v1 [] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
        logic [7:0] v2 [] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
        logic [7:0] v3 [] = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};
        logic [7:0] v4 [] = '{8'h77, 8'h81, 8'hB7};
        int cyc;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ks_ready = 1'b1;
        key = '0; key_length = 8'd0; drop_count = 16'd0; byte_count = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ks_data", 32'(ks_data),  32'd0);
        check("rst_valid",   32'(ks_valid), 32'd0);
        check("rst_busy",    32'(busy),     32'd0);
        check("rst_done",    32'(done),     32'd0);
        check("rst_key_err", 32'(key_err),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: "Key", counted 9
        push_bytes(v1, 9);
        start_run(KEY_KEY, 3, 0, 9);
        check("t1_busy", 32'(busy), 32'd1);
        wait_drain("t1", 600);
        check_done("t1");

        // 2: "Wiki" and "Secret", each restarted from DONE
        push_bytes(v2, 6);
        start_run(KEY_WIKI, 4, 0, 6);
        wait_drain("t2w", 600);
        check_done("t2w");
        push_bytes(v3, 8);
        start_run(KEY_SECRET, 6, 0, 8);
        wait_drain("t2s", 600);
        check_done("t2s");

        // 3: drop 2 with first-valid latency measured from the start edge
        push_bytes(v4, 3);
        start_run(KEY_KEY, 3, 2, 3);
        cyc = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (ks_valid) break;
            @(posedge clk);
            cyc++;
        end
        check("t3_latency", 32'(cyc), 32'd260);
        @(posedge clk); #1;
        wait_drain("t3", 100);
        check_done("t3");

        // 4: unbounded with random back-pressure
        push_model(KEY_KEY, 3, 0, 20);
        start_run(KEY_KEY, 3, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            if (exp_q.size() == 0) break;
            ks_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ks_ready = 1'b0;
        check("t4_drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("t4_busy_unbounded", 32'(busy), 32'd1);
        do_abort("t4_abort");
        ks_ready = 1'b1;

        // 5: bad key lengths, then start while keying
        start_run(KEY_KEY, 0, 0, 4);
        check("t5_len0_err",    32'(key_err), 32'd1);
        check("t5_len0_busy",   32'(busy),    32'd0);
        @(posedge clk); #1;
        check("t5_len0_pulse",  32'(key_err), 32'd0);
        start_run(KEY_KEY, 17, 0, 4);
        check("t5_len17_err",   32'(key_err), 32'd1);
        check("t5_len17_busy",  32'(busy),    32'd0);
        @(posedge clk); #1;
        check("t5_len17_pulse", 32'(key_err), 32'd0);
        push_bytes(v1, 3);
        start_run(KEY_KEY, 3, 0, 3);
        repeat (50) @(posedge clk);
        #1;
        start_run(KEY_WIKI, 4, 0, 6);
        check("t5_ksa_start_err", 32'(key_err), 32'd0);
        check("t5_ksa_busy",      32'(busy),    32'd1);
        wait_drain("t5", 600);
        check_done("t5");

        // 6: abort mid-KSA, abort mid-PRGA, restart, reset mid-PRGA
        start_run(KEY_KEY, 3, 0, 9);
        repeat (100) @(posedge clk);
        #1;
        do_abort("t6_ksa");
        ks_ready = 1'b0;
        start_run(KEY_KEY, 3, 0, 0);
        repeat (270) @(posedge clk);
        #1;
        check("t6_hold_valid", 32'(ks_valid), 32'd1);
        check("t6_hold_data",  32'(ks_data),  32'hEB);
        do_abort("t6_prga");
        ks_ready = 1'b1;
        push_bytes(v1, 9);
        start_run(KEY_KEY, 3, 0, 9);
        wait_drain("t6_restart", 600);
        check_done("t6_restart");
        ks_ready = 1'b0;
        start_run(KEY_KEY, 3, 0, 0);
        repeat (270) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_data",    32'(ks_data),  32'd0);
        check("t6_rst_valid",   32'(ks_valid), 32'd0);
        check("t6_rst_busy",    32'(busy),     32'd0);
        check("t6_rst_done",    32'(done),     32'd0);
        check("t6_rst_key_err", 32'(key_err),  32'd0);
        rst_n = 1'b1;
        ks_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
